// File: rtl/maxnet_pkg.sv
// ----------------------------------------------------------------------
// maxnet_pkg : shared state encoding and width helpers for the Maxnet
// Revision 1.0
// ----------------------------------------------------------------------
`default_nettype none

package maxnet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Activations carry one fractional bit per bit of epsilon shift.
  function automatic int act_frac(input int eps_shift);
    return eps_shift;
  endfunction

  function automatic int act_width(input int w, input int eps_shift);
    return w + act_frac(eps_shift);
  endfunction

endpackage

`default_nettype wire

// File: rtl/maxnet_pe.sv
// ----------------------------------------------------------------------
// maxnet_pe : one channel's lateral-inhibit and zero-clamp datapath
// Revision 1.0
// ----------------------------------------------------------------------
`default_nettype none

module maxnet_pe #(
  parameter int A         = 8,
  parameter int SW        = 10,
  parameter int EPS_SHIFT = 3
) (
  input  logic [A-1:0]  a,
  input  logic [SW-1:0] s,
  output logic [A-1:0]  a_next,
  output logic          nonzero,
  output logic          next_nonzero
);

  // One guard bit so the ceil bias cannot wrap.
  localparam int OW = SW + 1;

  logic [OW-1:0] others;
  logic [OW-1:0] inh;

  always_comb begin
    others = OW'(s) - OW'(a);
    inh    = (others + OW'((1 << EPS_SHIFT) - 1)) >> EPS_SHIFT;
    a_next = (OW'(a) > inh) ? (a - inh[A-1:0]) : '0;
  end

  assign nonzero      = |a;
  assign next_nonzero = |a_next;

endmodule

`default_nettype wire

// File: rtl/maxnet_param.sv
// ----------------------------------------------------------------------
// maxnet_param : N-input Maxnet winner-take-all; MAXNET_TIMEOUT_EN adds cap
// Revision 1.0
// ----------------------------------------------------------------------
`default_nettype none

module maxnet_param
  import maxnet_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 5,
  parameter int EPS_SHIFT = 3,
  parameter int MAX_ITER  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*W-1:0]          x,
  output logic                    busy,
  output logic                    done,
  output logic [W-1:0]            result,
  output logic [idx_width(N)-1:0] winner_idx,
  output logic                    tie,
  output logic                    timeout
);

  localparam int A   = act_width(W, EPS_SHIFT);
  localparam int IW  = idx_width(N);
  localparam int SW  = A + $clog2(N);
  localparam int NCW = $clog2(N + 1);

  state_t         state;
  logic [A-1:0]   act    [N];
  logic [W-1:0]   snap   [N];
  logic [A-1:0]   a_next [N];
  logic           nzf    [N];
  logic           nnz    [N];

  logic [SW-1:0]  sum;
  logic [NCW-1:0] nz_cnt;
  logic [IW-1:0]  first_idx;
  logic           found;
  logic           any_next;
  logic           finish;
  logic [IW-1:0]  fin_idx;
  logic           fin_tie;
  logic           fin_to;

  generate
    for (genvar g = 0; g < N; g++) begin : g_pe
      maxnet_pe #(.A(A), .SW(SW), .EPS_SHIFT(EPS_SHIFT)) u_pe (
        .a            (act[g]),
        .s            (sum),
        .a_next       (a_next[g]),
        .nonzero      (nzf[g]),
        .next_nonzero (nnz[g])
      );
    end
  endgenerate

`ifdef MAXNET_TIMEOUT_EN
  localparam int CW = (MAX_ITER > 255) ? 16 : 8;

  logic [CW-1:0] iter_cnt;
  logic [IW-1:0] best_idx;
  logic [A-1:0]  best_val;
  logic          timeout_flag;

  // Strict compare keeps the lowest index among equal leaders.
  always_comb begin
    best_idx = '0;
    best_val = act[0];
    for (int i = 1; i < N; i++) begin
      if (act[i] > best_val) begin
        best_val = act[i];
        best_idx = IW'(i);
      end
    end
  end

  assign timeout = timeout_flag;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    sum       = '0;
    nz_cnt    = '0;
    first_idx = '0;
    found     = 1'b0;
    any_next  = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum    = sum + SW'(act[i]);
      nz_cnt = nz_cnt + NCW'(nzf[i]);
      any_next = any_next | nnz[i];
      if (nzf[i] && !found) begin
        first_idx = IW'(i);
        found     = 1'b1;
      end
    end

    finish  = 1'b0;
    fin_idx = first_idx;
    fin_tie = 1'b0;
    fin_to  = 1'b0;
    if (nz_cnt <= NCW'(1)) begin
      finish  = 1'b1;
      fin_tie = (nz_cnt == '0);
`ifdef MAXNET_TIMEOUT_EN
    end else if (iter_cnt == CW'(MAX_ITER)) begin
      finish  = 1'b1;
      fin_idx = best_idx;
      fin_tie = 1'b1;
      fin_to  = 1'b1;
`endif
    end else if (!any_next) begin
      finish  = 1'b1;
      fin_tie = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      winner_idx <= '0;
      tie        <= 1'b0;
      for (int i = 0; i < N; i++) begin
        act[i]  <= '0;
        snap[i] <= '0;
      end
`ifdef MAXNET_TIMEOUT_EN
      iter_cnt     <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              act[i]  <= A'(x[i*W +: W]) << EPS_SHIFT;
              snap[i] <= x[i*W +: W];
            end
            busy       <= 1'b1;
            result     <= '0;
            winner_idx <= '0;
            tie        <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
            iter_cnt     <= '0;
            timeout_flag <= 1'b0;
`endif
            state <= LOAD;
          end
        end
        LOAD: state <= ITER;
        ITER: begin
          if (finish) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            winner_idx <= fin_idx;
            tie        <= fin_tie;
            result     <= snap[fin_idx];
`ifdef MAXNET_TIMEOUT_EN
            timeout_flag <= fin_to;
`endif
            state <= DONE;
          end else begin
            for (int i = 0; i < N; i++) act[i] <= a_next[i];
`ifdef MAXNET_TIMEOUT_EN
            iter_cnt <= iter_cnt + CW'(1);
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_maxnet_param.sv
// ----------------------------------------------------------------------
// tb_maxnet_param : directed self-checking bench for maxnet_param
// Revision 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_maxnet_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [19:0] x;
  logic        busy, done, tie, timeout;
  logic [4:0]  result;
  logic [1:0]  widx;

  logic        start8;
  logic [63:0] x8;
  logic        busy8, done8, tie8, to8;
  logic [7:0]  result8;
  logic [2:0]  widx8;

  int tests = 0;
  int fails = 0;

  logic [4:0] c_res;
  logic [1:0] c_idx;
  logic       c_tie, c_to, c_busy_after, c_done_after;

  maxnet_param #(.N(4), .W(5), .EPS_SHIFT(3), .MAX_ITER(255)) u_dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .busy(busy), .done(done),
    .result(result), .winner_idx(widx), .tie(tie), .timeout(timeout)
  );

  maxnet_param #(.N(8), .W(8), .EPS_SHIFT(4), .MAX_ITER(255)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .x(x8), .busy(busy8), .done(done8),
    .result(result8), .winner_idx(widx8), .tie(tie8), .timeout(to8)
  );

`ifdef MAXNET_TIMEOUT_EN
  logic        start_t, busy_t, done_t, tie_t, to_t;
  logic [4:0]  result_t;
  logic [1:0]  widx_t;

  maxnet_param #(.N(4), .W(5), .EPS_SHIFT(3), .MAX_ITER(2)) u_dut_t (
    .clk(clk), .rst(rst), .start(start_t), .x(x), .busy(busy_t), .done(done_t),
    .result(result_t), .winner_idx(widx_t), .tie(tie_t), .timeout(to_t)
  );
`endif

  function automatic logic [19:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {a3[4:0], a2[4:0], a1[4:0], a0[4:0]};
  endfunction

  // Pulses start for one cycle, waits for done and snapshots the outputs.
  // cyc counts cycles after the capture edge (1 = LOAD); -1 means no done.
  task automatic run4(input logic [19:0] xv, output int cyc);
    @(negedge clk); x = xv; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    if (done === 1'b1) begin
      c_res = result; c_idx = widx; c_tie = tie; c_to = timeout;
    end else begin
      cyc = -1;
    end
    @(negedge clk);
    c_busy_after = busy; c_done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; start8 = 1'b0; x = '0; x8 = '0;
`ifdef MAXNET_TIMEOUT_EN
    start_t = 1'b0;
`endif
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, result, widx, tie, timeout} !== 11'd0) begin
      fails++; $display("FAIL reset_outputs: got %b, required 0", {busy, done, result, widx, tie, timeout});
    end
    tests++;
    if ({busy8, done8, result8, widx8, tie8, to8} !== 15'd0) begin
      fails++; $display("FAIL reset_outputs8: got %b, required 0", {busy8, done8, result8, widx8, tie8, to8});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    run4(pack4(2, 7, 1, 6), cyc);
    tests++;
    if (cyc != 12) begin fails++; $display("FAIL basic_latency: got %0d, required 12", cyc); end
    tests++;
    if (c_res !== 5'd7) begin fails++; $display("FAIL basic_result: got %0d, required 7", c_res); end
    tests++;
    if (c_idx !== 2'd1) begin fails++; $display("FAIL basic_idx: got %0d, required 1", c_idx); end
    tests++;
    if (c_tie !== 1'b0) begin fails++; $display("FAIL basic_tie: got %b, required 0", c_tie); end
    tests++;
    if (c_to !== 1'b0) begin fails++; $display("FAIL basic_timeout: got %b, required 0", c_to); end
    tests++;
    if ({c_busy_after, c_done_after} !== 2'b00) begin
      fails++; $display("FAIL basic_after_done: busy/done got %b, required 00", {c_busy_after, c_done_after});
    end
  endtask

  task automatic test_tie();
    int cyc;
    run4(pack4(5, 5, 1, 0), cyc);
    tests++;
    if (cyc < 0 || c_tie !== 1'b1 || c_idx !== 2'd0 || c_res !== 5'd5) begin
      fails++;
      $display("FAIL tie_equal: cyc=%0d tie=%b idx=%0d res=%0d, required tie=1 idx=0 res=5", cyc, c_tie, c_idx, c_res);
    end
  endtask

  task automatic test_single();
    int cyc;
    run4(pack4(0, 0, 9, 0), cyc);
    tests++;
    if (cyc != 3) begin fails++; $display("FAIL single_latency: got %0d, required 3", cyc); end
    tests++;
    if (c_idx !== 2'd2 || c_res !== 5'd9 || c_tie !== 1'b0) begin
      fails++; $display("FAIL single_result: idx=%0d res=%0d tie=%b, required idx=2 res=9 tie=0", c_idx, c_res, c_tie);
    end
  endtask

  task automatic test_all_zero();
    int cyc;
    run4(pack4(0, 0, 0, 0), cyc);
    tests++;
    if (cyc != 3) begin fails++; $display("FAIL zero_latency: got %0d, required 3", cyc); end
    tests++;
    if (c_idx !== 2'd0 || c_res !== 5'd0 || c_tie !== 1'b1) begin
      fails++; $display("FAIL zero_result: idx=%0d res=%0d tie=%b, required idx=0 res=0 tie=1", c_idx, c_res, c_tie);
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    logic [4:0] r;
    logic [1:0] ix;
    ndone = 0; r = '0; ix = '0;
    @(negedge clk); x = pack4(2, 7, 1, 6); start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_in_load: got %b, required 1", busy); end
    @(negedge clk); start = 1'b1; x = pack4(31, 0, 0, 0);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ndone++; r = result; ix = widx; end
    end
    tests++;
    if (ndone != 1) begin fails++; $display("FAIL ignore_done_count: got %0d, required 1", ndone); end
    tests++;
    if (r !== 5'd7 || ix !== 2'd1) begin
      fails++; $display("FAIL ignore_result: res=%0d idx=%0d, required res=7 idx=1", r, ix);
    end
  endtask

  task automatic test_reset_mid_iter();
    int ndone, cyc;
    ndone = 0;
    @(negedge clk); x = pack4(2, 7, 1, 6); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, result, widx, tie, timeout} !== 11'd0) begin
      fails++; $display("FAIL mid_reset_outputs: got %b, required 0", {busy, done, result, widx, tie, timeout});
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    tests++;
    if (ndone != 0) begin fails++; $display("FAIL mid_reset_no_done: got %0d, required 0", ndone); end
    run4(pack4(0, 0, 9, 0), cyc);
    tests++;
    if (cyc != 3 || c_idx !== 2'd2 || c_res !== 5'd9) begin
      fails++; $display("FAIL mid_reset_restart: cyc=%0d idx=%0d res=%0d, required 3/2/9", cyc, c_idx, c_res);
    end
  endtask

  task automatic test_param8();
    int cyc;
    @(negedge clk);
    x8 = {8'd1, 8'd77, 8'd50, 8'd0, 8'd199, 8'd3, 8'd200, 8'd10};
    start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; cyc = 1;
    while (done8 !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
    tests++;
    if (done8 !== 1'b1) begin
      fails++; $display("FAIL param8_done: no done within 2000 cycles, required done");
    end else if (widx8 !== 3'd1 || result8 !== 8'd200 || tie8 !== 1'b0 || to8 !== 1'b0) begin
      fails++;
      $display("FAIL param8_result: idx=%0d res=%0d tie=%b to=%b, required idx=1 res=200 tie=0 to=0", widx8, result8, tie8, to8);
    end
  endtask

`ifdef MAXNET_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    @(negedge clk); x = pack4(2, 7, 1, 6); start_t = 1'b1;
    @(negedge clk); start_t = 1'b0; cyc = 1;
    while (done_t !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
    tests++;
    if (cyc != 5 || to_t !== 1'b1 || tie_t !== 1'b1 || widx_t !== 2'd1 || result_t !== 5'd7) begin
      fails++;
      $display("FAIL timeout_cap: cyc=%0d to=%b tie=%b idx=%0d res=%0d, required 5/1/1/1/7", cyc, to_t, tie_t, widx_t, result_t);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_single();
    test_all_zero();
    test_ignore_start();
    test_reset_mid_iter();
    test_param8();
`ifdef MAXNET_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
